pipe_elastic_stage: RTL and testbench

Parametrised elastic pipeline register that replaces fixed enable-only stage registers such as EX/MEM and MEM/WB. It holds up to DEPTH in-flight entries in a circular buffer. Each entry carries an opaque payload plus destination-register tag fields. Stall control uses a valid/ready handshake instead of a global enable, and the block adds a synchronous flush and a forwarding/hazard lookup across all buffered entries.

---
 rtl/pipe_elastic_stage.sv | 132 +++++++++++++
 tb/tb_pipe_elastic_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready, flush and hazard lookup.
// Optional macro PIPE_ELASTIC_STATS_EN adds stall/bubble/flush statistics outputs.
module pipe_elastic_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [RD_W-1:0]              in_rd_addr,
    input  logic                         in_rd_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [RD_W-1:0]              out_rd_addr,
    output logic                         out_rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [RD_W-1:0]              qry_addr,
    output logic                         qry_hit,
    output logic [DATA_W-1:0]            qry_data
`ifdef PIPE_ELASTIC_STATS_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  bubble_cycles,
    output logic [15:0]                  flush_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_q     [DEPTH];
    logic [RD_W-1:0]   rd_addr_q  [DEPTH];
    logic              rd_valid_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_c;
    logic              pop_c;
    logic [PTR_W-1:0]  qry_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake derives only from registered occupancy: no in-to-out or ready-to-ready path.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;
    assign count     = count_q;

    assign out_data     = out_valid ? data_q[head_q]     : '0;
    assign out_rd_addr  = out_valid ? rd_addr_q[head_q]  : '0;
    assign out_rd_valid = out_valid ? rd_valid_q[head_q] : 1'b0;

    // Buffer storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]     <= '0;
                rd_addr_q[i]  <= '0;
                rd_valid_q[i] <= 1'b0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) begin
                data_q[tail_q]     <= in_data;
                rd_addr_q[tail_q]  <= in_rd_addr;
                rd_valid_q[tail_q] <= in_rd_valid;
                tail_q             <= ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_q <= ptr_inc(head_q);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        qry_hit  = 1'b0;
        qry_data = '0;
        qry_idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            qry_idx = PTR_W'((int'(head_q) + k) % int'(DEPTH));
            if ((k < int'(count_q)) && (qry_addr != '0) &&
                rd_valid_q[qry_idx] && (rd_addr_q[qry_idx] == qry_addr)) begin
                qry_hit  = 1'b1;
                qry_data = data_q[qry_idx];
            end
        end
    end

`ifdef PIPE_ELASTIC_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
            flush_count   <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (out_ready && !out_valid && (bubble_cycles != '1)) begin
                bubble_cycles <= bubble_cycles + 32'd1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`else
    // Default build carries no statistics logic.
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed self-checking bench for pipe_elastic_stage (DEPTH=2).
module tb_pipe_elastic_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd_addr;
    logic              in_rd_valid;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd_addr;
    logic              out_rd_valid;
    logic [1:0]        count;
    logic [RD_W-1:0]   qry_addr;
    logic              qry_hit;
    logic [DATA_W-1:0] qry_data;
`ifdef PIPE_ELASTIC_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       bubble_cycles;
    logic [15:0]       flush_count;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_elastic_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_rd_addr   (in_rd_addr),
        .in_rd_valid  (in_rd_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd_addr  (out_rd_addr),
        .out_rd_valid (out_rd_valid),
        .count        (count),
        .qry_addr     (qry_addr),
        .qry_hit      (qry_hit),
        .qry_data     (qry_data)
`ifdef PIPE_ELASTIC_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles),
        .flush_count  (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_rd_addr = '0; in_rd_valid = 1'b0; out_ready = 1'b0; qry_addr = '0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_qry_hit", 64'(qry_hit), 64'd0);
        #10 rst = 1'b0;
        tick();

        // Single push, one-cycle latency
        in_valid = 1'b1; in_data = 32'hA5A5_0001; in_rd_addr = 5'd3; in_rd_valid = 1'b1; out_ready = 1'b1;
        #1 chk("t1_no_comb_path", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'hA5A5_0001);
        chk("t1_out_rd_addr", 64'(out_rd_addr), 64'd3);
        chk("t1_out_rd_valid", 64'(out_rd_valid), 64'd1);
        chk("t1_count", 64'(count), 64'd1);
        tick();
        chk("t1_drained_valid", 64'(out_valid), 64'd0);
        chk("t1_drained_data", 64'(out_data), 64'd0);

        // Full-throughput streaming
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            in_rd_addr = 5'(i);
            #1 chk("t2_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("t2_out_valid", 64'(out_valid), 64'd1);
            chk("t2_out_data", 64'(out_data), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t2_final_count", 64'(count), 64'd0);

        // Backpressure, full buffer, wrap
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        tick();
        chk("t3_count1", 64'(count), 64'd1);
        chk("t3_ready1", 64'(in_ready), 64'd1);
        in_data = 32'h2;
        tick();
        chk("t3_count2", 64'(count), 64'd2);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        in_data = 32'h3;
        tick();
        chk("t3_held_count", 64'(count), 64'd2);
        chk("t3_head1", 64'(out_data), 64'h1);
        out_ready = 1'b1;
        tick();
        chk("t3_head2", 64'(out_data), 64'h2);
        chk("t3_count_after_pop", 64'(count), 64'd1);
        tick();
        chk("t3_head3", 64'(out_data), 64'h3);
        chk("t3_count_pushpop", 64'(count), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("t3_empty", 64'(out_valid), 64'd0);

        // Flush at full occupancy with push attempt
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("t4_full", 64'(count), 64'd2);
        flush = 1'b1; in_data = 32'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_flush_count", 64'(count), 64'd0);
        chk("t4_flush_valid", 64'(out_valid), 64'd0);
        chk("t4_flush_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t4_no_ghost", 64'(out_valid), 64'd0);
        // Flush with concurrent accepted push and pop
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        chk("t4b_count1", 64'(count), 64'd1);
        in_data = 32'h55; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t4b_count", 64'(count), 64'd0);
        tick();
        chk("t4b_no_ghost", 64'(out_valid), 64'd0);

        // Hazard lookup
        in_valid = 1'b1; in_data = 32'h10; in_rd_addr = 5'd5; in_rd_valid = 1'b1; qry_addr = 5'd5;
        #1 chk("t5_push_invisible", 64'(qry_hit), 64'd0);
        tick();
        chk("t5_hit_one", 64'(qry_hit), 64'd1);
        chk("t5_data_one", 64'(qry_data), 64'h10);
        in_data = 32'h20;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_hit_two", 64'(qry_hit), 64'd1);
        chk("t5_youngest", 64'(qry_data), 64'h20);
        qry_addr = 5'd0;
        #1;
        chk("t5_r0_hit", 64'(qry_hit), 64'd0);
        chk("t5_r0_data", 64'(qry_data), 64'd0);
        qry_addr = 5'd6;
        #1 chk("t5_miss", 64'(qry_hit), 64'd0);
        qry_addr = 5'd5; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_after_pop_hit", 64'(qry_hit), 64'd1);
        chk("t5_after_pop_data", 64'(qry_data), 64'h20);
        chk("t5_after_pop_count", 64'(count), 64'd1);
        in_valid = 1'b1; in_data = 32'h30; in_rd_valid = 1'b0;
        tick();
        in_valid = 1'b0; in_rd_valid = 1'b1;
        #1 chk("t5_nowrite_ignored", 64'(qry_data), 64'h20);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("t5_empty_hit", 64'(qry_hit), 64'd0);
        chk("t5_empty_data", 64'(qry_data), 64'd0);
        chk("t5_empty_count", 64'(count), 64'd0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 32'h66; in_rd_addr = 5'd2;
        tick();
        in_valid = 1'b0;
        chk("t6_pre_count", 64'(count), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_data", 64'(out_data), 64'd0);
        chk("t6_async_ready", 64'(in_ready), 64'd1);
        #2 rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("t6_first_push_valid", 64'(out_valid), 64'd1);
        chk("t6_first_push_data", 64'(out_data), 64'h77);
        chk("t6_first_push_count", 64'(count), 64'd1);
`ifdef PIPE_ELASTIC_STATS_EN
        in_valid = 1'b1; in_data = 32'h88;
        tick();
        chk("t6_stats_full", 64'(count), 64'd2);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("t6_stall_cycles", 64'(stall_cycles), 64'd3);
        chk("t6_flush_count", 64'(flush_count), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
